// File: rtl/vga_pattern_gen.sv
// Test-pattern source for the vga_controller pixel pipeline: five patterns, one registered cycle
// from pixel position to RGB, with a debounced button that selects the pattern at the next frame start.
module vga_pattern_gen #(
  parameter int H_BITS        = 11,
  parameter int V_BITS        = 10,
  parameter int H_ACTIVE      = 800,
  parameter int V_ACTIVE      = 600,
  parameter int COLOR_BITS    = 1,
  parameter int CHECK_LOG2    = 5,
  parameter int DEBOUNCE_BITS = 16,
  parameter int RESET_MODE    = 0
) (
  input  logic                  clk_px,
  input  logic                  i_rst_n,
  input  logic [H_BITS-1:0]     i_pos_h,
  input  logic [V_BITS-1:0]     i_pos_v,
  input  logic                  i_btn,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_green,
  output logic [COLOR_BITS-1:0] o_blue,
  output logic [2:0]            o_mode,
  output logic [7:0]            o_frame
);

  localparam int                     BAR_W    = H_ACTIVE / 8;
  localparam logic [H_BITS-1:0]      H_ACT    = H_BITS'(H_ACTIVE);
  localparam logic [H_BITS-1:0]      H_LAST   = H_BITS'(H_ACTIVE - 1);
  localparam logic [V_BITS-1:0]      V_ACT    = V_BITS'(V_ACTIVE);
  localparam logic [V_BITS-1:0]      V_LAST   = V_BITS'(V_ACTIVE - 1);
  localparam logic [H_BITS-1:0]      BAR_LAST = H_BITS'(BAR_W - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;
  localparam logic [2:0]             MODE_RST = 3'(RESET_MODE);

  logic                     r_btn_s1, r_btn_s2, r_btn_stable;
  logic [DEBOUNCE_BITS-1:0] r_db_cnt;
  logic [2:0]               r_pending, r_mode;
  logic [7:0]               r_frame;
  logic [H_BITS-1:0]        r_sub;
  logic [2:0]               r_bar;
  logic [COLOR_BITS-1:0]    r_red, r_green, r_blue;

  logic                     w_frame_start, w_db_diff, w_db_done, w_press;
  logic [2:0]               w_mode, w_pending_nx, w_bar_cur, w_rgb;
  logic [7:0]               w_frame;
  logic [H_BITS-1:0]        w_sub_cur, w_scroll;

  assign w_frame_start = (i_pos_h == '0) && (i_pos_v == '0);
  // The pixel on the frame-start cycle already shows the new mode and frame number.
  assign w_mode        = w_frame_start ? r_pending : r_mode;
  assign w_frame       = w_frame_start ? (r_frame + 8'd1) : r_frame;

  assign w_db_diff     = (r_btn_s2 != r_btn_stable);
  assign w_db_done     = w_db_diff && (r_db_cnt == DB_MAX);
  assign w_press       = w_db_done && r_btn_s2;
  assign w_pending_nx  = (r_pending == 3'd4) ? 3'd0 : (r_pending + 3'd1);

  // Bar position for the current pixel; h==0 restarts the line regardless of stored state.
  assign w_sub_cur     = (i_pos_h == '0) ? '0 : r_sub;
  assign w_bar_cur     = (i_pos_h == '0) ? 3'd0 : r_bar;
  assign w_scroll      = i_pos_h + H_BITS'(i_pos_v) + H_BITS'(w_frame);

  always_comb begin
    w_rgb = 3'b000;
    if (i_pos_h < H_ACT && i_pos_v < V_ACT) begin
      case (w_mode)
        3'd0: w_rgb = {i_pos_h[1:0] == 2'd0, i_pos_h[2:0] == 3'd0, i_pos_h[3:0] == 4'd0};
        3'd1: w_rgb = {(i_pos_h == '0) || (i_pos_h == H_LAST),
                       (i_pos_v == '0) || (i_pos_v == V_LAST), 1'b0};
        3'd2: w_rgb = 3'd7 - w_bar_cur;
        3'd3: w_rgb = {3{~(i_pos_h[CHECK_LOG2] ^ i_pos_v[CHECK_LOG2])}};
        3'd4: w_rgb = w_scroll[5:3];
        default: w_rgb = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk_px) begin
    if (!i_rst_n) begin
      r_btn_s1     <= 1'b0;
      r_btn_s2     <= 1'b0;
      r_btn_stable <= 1'b0;
      r_db_cnt     <= '0;
      r_pending    <= MODE_RST;
      r_mode       <= MODE_RST;
      r_frame      <= 8'd0;
      r_sub        <= '0;
      r_bar        <= 3'd0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
    end else begin
      r_btn_s1 <= i_btn;
      r_btn_s2 <= r_btn_s1;

      if (!w_db_diff) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_btn_stable <= r_btn_s2;
        r_db_cnt     <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end

      // A press coinciding with frame start lands in pending only; display picks it up next frame.
      if (w_press) r_pending <= w_pending_nx;

      if (w_frame_start) begin
        r_mode  <= r_pending;
        r_frame <= r_frame + 8'd1;
      end

      if (w_sub_cur == BAR_LAST) begin
        r_sub <= '0;
        r_bar <= (w_bar_cur == 3'd7) ? 3'd7 : (w_bar_cur + 3'd1);
      end else begin
        r_sub <= w_sub_cur + 1'b1;
        r_bar <= w_bar_cur;
      end

      r_red   <= {COLOR_BITS{w_rgb[2]}};
      r_green <= {COLOR_BITS{w_rgb[1]}};
      r_blue  <= {COLOR_BITS{w_rgb[0]}};
    end
  end

  assign o_red   = r_red;
  assign o_green = r_green;
  assign o_blue  = r_blue;
  assign o_mode  = r_mode;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: stimulus queues expected pixels, a monitor checks them one cycle later.
module tb_vga_pattern_gen;

  localparam int CB = 2;
  localparam int DB = 4;

  logic          clk_px = 1'b0;
  logic          i_rst_n;
  logic [10:0]   i_pos_h;
  logic [9:0]    i_pos_v;
  logic          i_btn;
  logic [CB-1:0] o_red, o_green, o_blue;
  logic [2:0]    o_mode;
  logic [7:0]    o_frame;

  typedef struct packed {
    logic [2:0] rgb;
    logic [2:0] mode;
    logic [7:0] frame;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  tb_vld   = 1'b0;
  logic  tb_vld_q = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;
  logic [2:0] exp_mode  = 3'd0;
  logic [7:0] exp_frame = 8'd0;

  vga_pattern_gen #(
    .H_BITS(11), .V_BITS(10), .H_ACTIVE(800), .V_ACTIVE(600),
    .COLOR_BITS(CB), .CHECK_LOG2(5), .DEBOUNCE_BITS(DB), .RESET_MODE(0)
  ) dut (
    .clk_px(clk_px), .i_rst_n(i_rst_n), .i_pos_h(i_pos_h), .i_pos_v(i_pos_v),
    .i_btn(i_btn), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_mode(o_mode), .o_frame(o_frame)
  );

  always #5 clk_px = ~clk_px;

  always @(posedge clk_px) tb_vld_q <= tb_vld;

  function automatic logic [2:0] stripe(int h);
    if (h >= 800) return 3'b000;
    return {(h % 4) == 0, (h % 8) == 0, (h % 16) == 0};
  endfunction

  function automatic logic [2:0] scroll(int h, int v, int f);
    return 3'(((h + v + f) % 2048) / 8 % 8);
  endfunction

  task automatic drive(input logic rst, input int h, input int v, input logic btn,
                       input logic [2:0] rgb, input string nm);
    exp_t e;
    @(negedge clk_px);
    i_rst_n = rst;
    i_pos_h = 11'(h);
    i_pos_v = 10'(v);
    i_btn   = btn;
    tb_vld  = 1'b1;
    e.rgb   = rgb;
    e.mode  = exp_mode;
    e.frame = exp_frame;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Debounced press then release, parked in blanking so the display stays black.
  task automatic press();
    for (int k = 0; k < (1 << DB) + 5; k++) drive(1'b1, 900, 700, 1'b1, 3'b000, "press_hold");
    for (int k = 0; k < (1 << DB) + 4; k++) drive(1'b1, 900, 700, 1'b0, 3'b000, "press_rel");
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    logic [CB-1:0] er, eg, eb;
    forever begin
      @(negedge clk_px);
      if (tb_vld_q) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty: output seen with no expected entry");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          er = {CB{e.rgb[2]}};
          eg = {CB{e.rgb[1]}};
          eb = {CB{e.rgb[0]}};
          if (o_red !== er || o_green !== eg || o_blue !== eb ||
              o_mode !== e.mode || o_frame !== e.frame) begin
            n_err++;
            $display("FAIL %s: got r=%b g=%b b=%b mode=%0d frame=%0d, want r=%b g=%b b=%b mode=%0d frame=%0d",
                     nm, o_red, o_green, o_blue, o_mode, o_frame, er, eg, eb, e.mode, e.frame);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    i_rst_n = 1'b0;
    i_pos_h = '0;
    i_pos_v = '0;
    i_btn   = 1'b0;

    for (int k = 0; k < 3; k++) drive(1'b0, 5, 5, 1'b0, 3'b000, "reset");
    drive(1'b1, 4, 0, 1'b0, 3'b100, "first_pixel");

    exp_frame = 8'd1;
    drive(1'b1, 0, 0, 1'b0, 3'b111, "frame_start_1");
    for (int h = 0; h < 1056; h++) drive(1'b1, h, 10, 1'b0, stripe(h), "stripes");
    drive(1'b1, 4, 600, 1'b0, 3'b000, "vblank");
    drive(1'b1, 799, 599, 1'b0, 3'b000, "last_pixel");

    // Short glitch must not reach the stable level.
    for (int k = 0; k < 8; k++) drive(1'b1, 900, 700, 1'b1, 3'b000, "glitch");
    for (int k = 0; k < 10; k++) drive(1'b1, 900, 700, 1'b0, 3'b000, "glitch_rel");
    exp_frame = 8'd2;
    drive(1'b1, 0, 0, 1'b0, 3'b111, "glitch_no_mode");

    press();
    exp_frame = 8'd3; exp_mode = 3'd1;
    drive(1'b1, 0, 0, 1'b0, 3'b110, "border_corner");
    drive(1'b1, 799, 300, 1'b0, 3'b100, "border_right");
    drive(1'b1, 400, 599, 1'b0, 3'b010, "border_bottom");
    drive(1'b1, 400, 300, 1'b0, 3'b000, "border_mid");

    press();
    exp_frame = 8'd4; exp_mode = 3'd2;
    drive(1'b1, 0, 0, 1'b0, 3'b111, "bars");
    for (int h = 1; h < 800; h++) drive(1'b1, h, 0, 1'b0, 3'(7 - h / 100), "bars");
    drive(1'b1, 800, 0, 1'b0, 3'b000, "bars_blank");

    // Stable rising edge lands exactly on the frame-start edge (18th cycle of the hold).
    for (int k = 0; k < 17; k++) drive(1'b1, 900, 700, 1'b1, 3'b000, "coinc_hold");
    exp_frame = 8'd5;
    drive(1'b1, 0, 0, 1'b1, 3'b111, "coinc_keep_old");
    for (int k = 0; k < 3; k++) drive(1'b1, 900, 700, 1'b1, 3'b000, "coinc_hold");
    for (int k = 0; k < (1 << DB) + 4; k++) drive(1'b1, 900, 700, 1'b0, 3'b000, "coinc_rel");
    exp_frame = 8'd6; exp_mode = 3'd3;
    drive(1'b1, 0, 0, 1'b0, 3'b111, "coinc_next");
    drive(1'b1, 32, 0, 1'b0, 3'b000, "check");
    drive(1'b1, 32, 32, 1'b0, 3'b111, "check");
    drive(1'b1, 0, 32, 1'b0, 3'b000, "check");
    drive(1'b1, 31, 31, 1'b0, 3'b111, "check");
    drive(1'b1, 64, 40, 1'b0, 3'b000, "check");

    press();
    exp_frame = 8'd7; exp_mode = 3'd4;
    drive(1'b1, 0, 0, 1'b0, scroll(0, 0, 7), "scroll");
    drive(1'b1, 8, 0, 1'b0, scroll(8, 0, 7), "scroll");
    drive(1'b1, 100, 50, 1'b0, scroll(100, 50, 7), "scroll");
    for (int f = 0; f < 256; f++) begin
      exp_frame = exp_frame + 8'd1;
      drive(1'b1, 0, 0, 1'b0, scroll(0, 0, int'(exp_frame)), "scroll_fs");
      drive(1'b1, 8, 0, 1'b0, scroll(8, 0, int'(exp_frame)), "scroll_8");
    end

    // Fifth press wraps pending from 4 back to 0.
    press();
    exp_frame = exp_frame + 8'd1; exp_mode = 3'd0;
    drive(1'b1, 0, 0, 1'b0, 3'b111, "mode_wrap");

    exp_frame = 8'd0;
    drive(1'b0, 4, 10, 1'b0, 3'b000, "mid_reset");
    drive(1'b1, 4, 10, 1'b0, 3'b100, "after_reset");
    exp_frame = 8'd1;
    drive(1'b1, 0, 0, 1'b0, 3'b111, "after_reset_fs");

    @(negedge clk_px);
    tb_vld = 1'b0;
    @(negedge clk_px);
    @(negedge clk_px);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
